soft_grand_seq: RTL and testbench
=================================

# soft_grand_seq

Clocked, parametrised soft-GRAND decoder for short systematic binary linear codes. It accepts a hard-decision word and a reliability ranking of its bit positions, then tests one noise pattern per cycle. Patterns are tried least-reliable-first until the corrected word satisfies every parity check or a query budget runs out. It sits between the soft demodulator (the source of the word and ranks) and the downstream data sink, with valid/ready handshakes on both sides.

## Interface
- `N`, 8: code length in bits.
- `R`, 4: number of parity checks (N−K).
- `H_MASKS`, {8'b1110_1000, 8'b0111_0100, 8'b1011_0010, 8'b1101_0001}: R×N flattened. Row j occupies bits [j*N +: N]. Syndrome bit j = ^(word & row j).
- `MAX_QUERIES`, 256: query budget. Legal range 1..2^N.
- `RW`, $clog2(N): width of one rank entry (derived).
- `QW`, $clog2(MAX_QUERIES+1): width of the query count (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: word and ranks present.
- `in_ready` out 1: block can accept a word.
- `y_i` in N: hard-decision word, bit i = position i.
- `rank_i` in N*RW: entry r at [r*RW +: RW] is the bit position with the r-th lowest reliability. Entry 0 is the least reliable.
- `out_valid` out 1: result present.
- `out_ready` in 1: sink accepts the result.
- `c_o` out N: decoded word. Equals y on failure.
- `fail_o` out 1: budget exhausted without finding a codeword.
- `queries_o` out QW: number of patterns tested, including the successful one.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, register y and ranks, clear the query index q, go to SEARCH.
- SEARCH, one query per cycle:
  - Pattern e(q) = XOR over all r with q[r]=1 of (1<<rank[r]). q=0 is the all-zero pattern; q=1 flips the least reliable bit; q=2 flips the second; q=3 flips both; and so on.
  - Duplicate ranks are not checked. They cancel under XOR, and avoiding them is the caller's responsibility.
  - Candidate = y ^ e(q). If its syndrome is 0: register c=candidate, fail=0, queries=q+1, go to DONE.
  - Else if q+1 == MAX_QUERIES: register c=y, fail=1, queries=MAX_QUERIES, go to DONE.
  - Else q ← q+1.
- DONE:
  - `out_valid`=1. `c_o`, `fail_o`, `queries_o` are held stable while `out_ready`=0.
  - On `out_ready`, go to IDLE.
- `in_ready`=0 in SEARCH and DONE. There is no input buffering.
- q is N bits wide, and the search terminates before q can wrap.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `c_o`=0, `fail_o`=0, `queries_o`=0. Internal q and latched y/ranks are also 0.
- Latency: accept on edge t. The query with index k is evaluated in the cycle following edge t+k. `out_valid` rises after edge t+Q, where Q = `queries_o`. Minimum Q=1, i.e. `out_valid` is high in the second cycle after acceptance.
- Earliest next acceptance is the cycle after the `out_valid`&&`out_ready` handshake. Throughput is at most one word per Q+2 cycles.
- Reset asserted in any state returns to IDLE immediately. The in-flight word is discarded and no output is produced for it.
- `in_valid` while busy is ignored, and the source must hold its data.
- MAX_QUERIES=1 tests only y itself.

## Structure
- `soft_grand_pkg` holds:
  - the state enum (IDLE/SEARCH/DONE);
  - default masks for the (8,4) extended Hamming code;
  - a function `syndrome(word, masks)`.
- Sub-module `soft_grand_pattern_gen` is combinational. It maps (q, ranks) to e, with parameters N and RW.

## Test plan
Unless stated, ranks = {6,2,0,1,3,4,5,7} (entry 0 first), defaults, `out_ready`=1.
1. y=0000_0000 → c=0000_0000, fail=0, queries=1, `out_valid` two cycles after acceptance.
2. y=0100_0000 → c=0000_0000, queries=2. Then y=0100_0100 → c=0000_0000, queries=4 (q=1 and q=2 rejected).
3. y=1010_0100 with rank entry 0 = 0 → c=1010_0101, queries=2. Then y=0001_0111 → c=0001_0111, queries=1.
4. Instance with MAX_QUERIES=2, y=0100_0100 → fail=1, c=0100_0100, queries=2.
5. Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, extra `in_valid` ignored. Release → next word accepted the cycle after the handshake.
6. Assert `rst_n` low mid-SEARCH on word 0100_0100 → all outputs at reset values, `in_ready`=1. A subsequent y=0000_0000 decodes with queries=1.

Source files
------------

// File: rtl/soft_grand_pkg.sv
// Shared types, default parity masks and syndrome helper for the soft-GRAND decoder.
package soft_grand_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Parity-check matrix of the (8,4) extended Hamming code, row j at [j*8 +: 8].
    localparam logic [31:0] DEFAULT_H_MASKS = {8'b1110_1000, 8'b0111_0100,
                                               8'b1011_0010, 8'b1101_0001};

    localparam int SYN_MAX_N = 32;
    localparam int SYN_MAX_R = 16;

    // Masks use a fixed row stride of SYN_MAX_N so one function serves any N/R;
    // unused rows are zero and contribute a zero syndrome bit.
    function automatic logic [SYN_MAX_R-1:0] syndrome(
        input logic [SYN_MAX_N-1:0]           word,
        input logic [SYN_MAX_R*SYN_MAX_N-1:0] masks
    );
        logic [SYN_MAX_R-1:0] s;
        s = '0;
        for (int j = 0; j < SYN_MAX_R; j++) begin
            s[j] = ^(word & masks[j*SYN_MAX_N +: SYN_MAX_N]);
        end
        return s;
    endfunction

endpackage

// File: rtl/soft_grand_pattern_gen.sv
// Combinational noise-pattern generator: bit r of q flips the position held in rank entry r.
module soft_grand_pattern_gen #(
    parameter int N  = 8,
    parameter int RW = 3
) (
    input  logic [N-1:0]    q,
    input  logic [N*RW-1:0] ranks,
    output logic [N-1:0]    e
);

    logic [N-1:0] terms [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_term
            assign terms[gi] = q[gi] ? (N'(1) << ranks[gi*RW +: RW]) : '0;
        end
    endgenerate

    // Duplicate ranks cancel here by design; the caller must avoid them.
    always_comb begin
        e = '0;
        for (int r = 0; r < N; r++) begin
            e = e ^ terms[r];
        end
    end

endmodule

// File: rtl/soft_grand_seq.sv
// Sequential soft-GRAND decoder: tests one reliability-ordered noise pattern per cycle
// until the syndrome clears or the query budget is spent.
module soft_grand_seq
    import soft_grand_pkg::*;
#(
    parameter int             N           = 8,
    parameter int             R           = 4,
    parameter logic [R*N-1:0] H_MASKS     = DEFAULT_H_MASKS,
    parameter int             MAX_QUERIES = 256,
    parameter int             RW          = $clog2(N),
    parameter int             QW          = $clog2(MAX_QUERIES + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    y_i,
    input  logic [N*RW-1:0] rank_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    c_o,
    output logic            fail_o,
    output logic [QW-1:0]   queries_o
);

    state_t            state_reg, state_next;
    logic [N-1:0]      q_reg, q_next;
    logic [N-1:0]      y_reg, y_next;
    logic [N*RW-1:0]   ranks_reg, ranks_next;
    logic [N-1:0]      c_reg, c_next;
    logic              fail_reg, fail_next;
    logic [QW-1:0]     queries_reg, queries_next;

    logic [N-1:0]      pattern;
    logic [N-1:0]      candidate;
    logic [N:0]        q_plus;
    logic              syn_zero;
    logic [SYN_MAX_R*SYN_MAX_N-1:0] masks_wide;

    generate
        for (genvar gi = 0; gi < SYN_MAX_R; gi++) begin : g_mask
            if (gi < R) begin : g_used
                assign masks_wide[gi*SYN_MAX_N +: SYN_MAX_N] = SYN_MAX_N'(H_MASKS[gi*N +: N]);
            end else begin : g_unused
                assign masks_wide[gi*SYN_MAX_N +: SYN_MAX_N] = '0;
            end
        end
    endgenerate

    soft_grand_pattern_gen #(
        .N  (N),
        .RW (RW)
    ) u_pattern_gen (
        .q     (q_reg),
        .ranks (ranks_reg),
        .e     (pattern)
    );

    assign candidate = y_reg ^ pattern;
    assign syn_zero  = (syndrome(SYN_MAX_N'(candidate), masks_wide) == '0);
    assign q_plus    = {1'b0, q_reg} + (N+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            y_reg       <= '0;
            ranks_reg   <= '0;
            c_reg       <= '0;
            fail_reg    <= 1'b0;
            queries_reg <= '0;
        end else begin
            state_reg   <= state_next;
            q_reg       <= q_next;
            y_reg       <= y_next;
            ranks_reg   <= ranks_next;
            c_reg       <= c_next;
            fail_reg    <= fail_next;
            queries_reg <= queries_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        y_next       = y_reg;
        ranks_next   = ranks_reg;
        c_next       = c_reg;
        fail_next    = fail_reg;
        queries_next = queries_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    y_next     = y_i;
                    ranks_next = rank_i;
                    q_next     = '0;
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (syn_zero) begin
                    c_next       = candidate;
                    fail_next    = 1'b0;
                    queries_next = QW'(q_plus);
                    state_next   = DONE;
                end else if (q_plus == (N+1)'(MAX_QUERIES)) begin
                    c_next       = y_reg;
                    fail_next    = 1'b1;
                    queries_next = QW'(MAX_QUERIES);
                    state_next   = DONE;
                end else begin
                    q_next = q_plus[N-1:0];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign c_o       = c_reg;
    assign fail_o    = fail_reg;
    assign queries_o = queries_reg;

endmodule

// File: tb/tb_soft_grand_seq.sv
// Directed bench for soft_grand_seq: default instance plus a two-query-budget instance.
module tb_soft_grand_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic [7:0]  y;
    logic [23:0] ranks;
    logic        out_valid_a, out_valid_b;
    logic        out_ready;
    logic [7:0]  c_a, c_b;
    logic        fail_a, fail_b;
    logic [8:0]  queries_a;
    logic [1:0]  queries_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Entry 0 (least reliable) sits in the low bits.
    localparam logic [23:0] RANKS_STD = {3'd7, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0, 3'd2, 3'd6};
    localparam logic [23:0] RANKS_ALT = {3'd7, 3'd5, 3'd4, 3'd3, 3'd1, 3'd0, 3'd2, 3'd0};

    soft_grand_seq dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .y_i       (y),
        .rank_i    (ranks),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .c_o       (c_a),
        .fail_o    (fail_a),
        .queries_o (queries_a)
    );

    soft_grand_seq #(.MAX_QUERIES(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .y_i       (y),
        .rank_i    (ranks),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .c_o       (c_b),
        .fail_o    (fail_b),
        .queries_o (queries_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one word into the selected instance and collects its result.
    task automatic run_word(input bit sel, input logic [7:0] wy, input logic [23:0] wr,
                            output logic [7:0] oc, output logic of, output int oq,
                            output int lat, output logic acc);
        y     = wy;
        ranks = wr;
        if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        acc = sel ? in_ready_b : in_ready_a;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 0;
        while (!(sel ? out_valid_b : out_valid_a) && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        oc = sel ? c_b : c_a;
        of = sel ? fail_b : fail_a;
        oq = sel ? int'(queries_b) : int'(queries_a);
        $display("txn: dut=%0d y=%b c=%b fail=%0d queries=%0d latency=%0d",
                 sel, wy, oc, of, oq, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1;
        y = '0; ranks = RANKS_STD;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_a); end
        n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_a); end
        n_cmp++; if (c_a !== 8'h00) begin n_bad++; $display("FAIL reset_c got=%b want=00000000", c_a); end
        n_cmp++; if (fail_a !== 1'b0) begin n_bad++; $display("FAIL reset_fail got=%b want=0", fail_a); end
        n_cmp++; if (queries_a !== 9'd0) begin n_bad++; $display("FAIL reset_queries got=%0d want=0", queries_a); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_word();
        logic [7:0] c; logic f; int q; int lat; logic acc;
        run_word(1'b0, 8'b0000_0000, RANKS_STD, c, f, q, lat, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL zero_accept got=%b want=1", acc); end
        n_cmp++; if (c !== 8'b0000_0000) begin n_bad++; $display("FAIL zero_c got=%b want=00000000", c); end
        n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL zero_fail got=%b want=0", f); end
        n_cmp++; if (q !== 1) begin n_bad++; $display("FAIL zero_queries got=%0d want=1", q); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
    endtask

    task automatic test_order();
        logic [7:0] c; logic f; int q; int lat; logic acc;
        run_word(1'b0, 8'b0100_0000, RANKS_STD, c, f, q, lat, acc);
        n_cmp++; if (c !== 8'b0000_0000) begin n_bad++; $display("FAIL order1_c got=%b want=00000000", c); end
        n_cmp++; if (q !== 2) begin n_bad++; $display("FAIL order1_queries got=%0d want=2", q); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL order1_latency got=%0d want=2", lat); end
        run_word(1'b0, 8'b0100_0100, RANKS_STD, c, f, q, lat, acc);
        n_cmp++; if (c !== 8'b0000_0000) begin n_bad++; $display("FAIL order2_c got=%b want=00000000", c); end
        n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL order2_fail got=%b want=0", f); end
        n_cmp++; if (q !== 4) begin n_bad++; $display("FAIL order2_queries got=%0d want=4", q); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL order2_latency got=%0d want=4", lat); end
    endtask

    task automatic test_alt_ranks();
        logic [7:0] c; logic f; int q; int lat; logic acc;
        run_word(1'b0, 8'b1010_0100, RANKS_ALT, c, f, q, lat, acc);
        n_cmp++; if (c !== 8'b1010_0101) begin n_bad++; $display("FAIL alt1_c got=%b want=10100101", c); end
        n_cmp++; if (q !== 2) begin n_bad++; $display("FAIL alt1_queries got=%0d want=2", q); end
        run_word(1'b0, 8'b0001_0111, RANKS_STD, c, f, q, lat, acc);
        n_cmp++; if (c !== 8'b0001_0111) begin n_bad++; $display("FAIL alt2_c got=%b want=00010111", c); end
        n_cmp++; if (q !== 1) begin n_bad++; $display("FAIL alt2_queries got=%0d want=1", q); end
    endtask

    task automatic test_budget();
        logic [7:0] c; logic f; int q; int lat; logic acc;
        run_word(1'b1, 8'b0100_0100, RANKS_STD, c, f, q, lat, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL budget_accept got=%b want=1", acc); end
        n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL budget_fail got=%b want=1", f); end
        n_cmp++; if (c !== 8'b0100_0100) begin n_bad++; $display("FAIL budget_c got=%b want=01000100", c); end
        n_cmp++; if (q !== 2) begin n_bad++; $display("FAIL budget_queries got=%0d want=2", q); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL budget_latency got=%0d want=2", lat); end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready  = 1'b0;
        y          = 8'b0100_0000;
        ranks      = RANKS_STD;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency got=%0d want=2", lat); end
        y          = 8'b0100_0100;
        in_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid_a !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, out_valid_a); end
            n_cmp++; if (c_a !== 8'b0000_0000 || queries_a !== 9'd2 || fail_a !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold_data cyc=%0d got c=%b q=%0d f=%b want c=00000000 q=2 f=0", i, c_a, queries_a, fail_a);
            end
            n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready_a); end
        end
        $display("txn: dut=0 y=01000000 held 5 cycles c=%b queries=%0d", c_a, queries_a);
        out_ready = 1'b1;
        y         = 8'b0001_0111;
        @(posedge clk); #1;
        n_cmp++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            n_bad++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid_a, in_ready_a);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept got in_ready=%b want=0", in_ready_a); end
        lat = 0;
        while (!out_valid_a && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++; if (c_a !== 8'b0001_0111 || queries_a !== 9'd1 || lat !== 1) begin
            n_bad++; $display("FAIL bp_next_word got c=%b q=%0d lat=%0d want c=00010111 q=1 lat=1", c_a, queries_a, lat);
        end
        $display("txn: dut=0 y=00010111 c=%b queries=%0d latency=%0d", c_a, queries_a, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_search();
        logic [7:0] c; logic f; int q; int lat; logic acc;
        y          = 8'b0100_0100;
        ranks      = RANKS_STD;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready_a); end
        n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid_a); end
        n_cmp++; if (c_a !== 8'h00 || fail_a !== 1'b0 || queries_a !== 9'd0) begin
            n_bad++; $display("FAIL rst_mid_outputs got c=%b f=%b q=%0d want 0/0/0", c_a, fail_a, queries_a);
        end
        $display("txn: dut=0 y=01000100 aborted by reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_output cyc=%0d got=%b want=0", i, out_valid_a); end
        end
        run_word(1'b0, 8'b0000_0000, RANKS_STD, c, f, q, lat, acc);
        n_cmp++; if (acc !== 1'b1 || c !== 8'h00 || q !== 1 || lat !== 1) begin
            n_bad++; $display("FAIL rst_mid_after got acc=%b c=%b q=%0d lat=%0d want 1/00000000/1/1", acc, c, q, lat);
        end
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_order();
        test_alt_ranks();
        test_budget();
        test_backpressure();
        test_reset_mid_search();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
